// File: rtl/snake_input_encoder.sv
// snake_input_encoder: push-buttons -> synchronized, debounced, one-hot direction requests for snake_controller.
// Define SNAKE_INPUT_QUEUE_EN to add a one-deep buffer for a turn pressed while a request is still pending.
module snake_input_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clka,
  input  logic       restart,
  input  logic [3:0] btn_raw,
  input  logic [1:0] direction_state,
  output logic [3:0] direction_in,
  output logic       dir_valid,
  output logic       dir_rejected
);

  typedef enum logic [1:0] {
    IDLE,
    PENDING
`ifdef SNAKE_INPUT_QUEUE_EN
    , QUEUED
`endif
  } state_t;

  typedef enum logic [1:0] {V_IGNORE, V_ACCEPT, V_REJECT} verdict_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  function automatic logic [3:0] onehot(input logic [1:0] d);
    return 4'b0001 << d;
  endfunction

  function automatic logic [1:0] encode(input logic [3:0] oh);
    case (oh)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Up/down and left/right share bit 1 of the heading code, so a reversal differs only in bit 0.
  function automatic verdict_t judge(input logic [1:0] d, input logic [1:0] h);
    if (d == h)       return V_IGNORE;
    if (d[1] == h[1]) return V_REJECT;
    return V_ACCEPT;
  endfunction

  logic [3:0] sync1, sync2, level, level_d, press_q;

  always_ff @(posedge clka or negedge restart) begin
    if (!restart) begin
      sync1   <= '0;
      sync2   <= '0;
      level_d <= '0;
      press_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample its pre-edge input, so the pipeline shifts by one per clock.
      sync1   <= btn_raw;
      sync2   <= sync1;
      level_d <= level;
      press_q <= level & ~level_d;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_debounce
    logic [CNT_W-1:0] cnt;
    logic             lvl;

    always_ff @(posedge clka or negedge restart) begin
      if (!restart) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (sync2[i] == lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        lvl <= sync2[i];
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    assign level[i] = lvl;
  end

  state_t     state, state_n;
  logic [3:0] dir_n;
  logic       valid_n, rej_n;
  logic [1:0] evt_dir;
  logic       evt_any, match;
  verdict_t   v_ctrl, v_req;
`ifdef SNAKE_INPUT_QUEUE_EN
  logic [3:0] queue, queue_n;
`endif

  // Simultaneous presses: the lowest index wins, the rest vanish.
  always_comb begin
    evt_dir = 2'd0;
    if      (press_q[0]) evt_dir = 2'd0;
    else if (press_q[1]) evt_dir = 2'd1;
    else if (press_q[2]) evt_dir = 2'd2;
    else if (press_q[3]) evt_dir = 2'd3;
  end

  assign evt_any = |press_q;
  assign match   = (direction_state == encode(direction_in));
  assign v_ctrl  = judge(evt_dir, direction_state);
  assign v_req   = judge(evt_dir, encode(direction_in));

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    state_n = state;
    dir_n   = direction_in;
    valid_n = 1'b0;
    rej_n   = 1'b0;
`ifdef SNAKE_INPUT_QUEUE_EN
    queue_n = queue;
`endif
    case (state)
      IDLE, PENDING: begin
        if (state == IDLE || match) begin
          // Controller has caught up: judge against its applied heading.
          state_n = IDLE;
          if (evt_any) begin
            if (v_ctrl == V_ACCEPT) begin
              dir_n   = onehot(evt_dir);
              valid_n = 1'b1;
              state_n = PENDING;
            end else if (v_ctrl == V_REJECT) begin
              rej_n = 1'b1;
            end
          end
        end else if (evt_any) begin
          if (v_req == V_REJECT) begin
            rej_n = 1'b1;
          end else if (v_req == V_ACCEPT) begin
`ifdef SNAKE_INPUT_QUEUE_EN
            queue_n = onehot(evt_dir);
            state_n = QUEUED;
`else
            rej_n = 1'b1;
`endif
          end
        end
      end
`ifdef SNAKE_INPUT_QUEUE_EN
      QUEUED: begin
        // A press landing in the release cycle is dropped quietly so valid and rejected never coincide.
        if (match) begin
          dir_n   = queue;
          valid_n = 1'b1;
          state_n = PENDING;
        end else if (evt_any) begin
          rej_n = 1'b1;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge restart) begin
    if (!restart) begin
      state        <= IDLE;
      direction_in <= '0;
      dir_valid    <= 1'b0;
      dir_rejected <= 1'b0;
`ifdef SNAKE_INPUT_QUEUE_EN
      queue        <= '0;
`endif
    end else begin
      state        <= state_n;
      direction_in <= dir_n;
      dir_valid    <= valid_n;
      dir_rejected <= rej_n;
`ifdef SNAKE_INPUT_QUEUE_EN
      queue        <= queue_n;
`endif
    end
  end

endmodule
